// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path.
//  - ALU op codes, shared with the ALU itself.
//  - RV32I major opcodes and funct7 values decoded by the operand stage.
//  - Operand bundle width: {alu_op, src1, src2, rd, illegal}.
package alu_pkg;

    localparam int unsigned ALU_XLEN  = 32;
    localparam int unsigned ALU_RF_AW = 5;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_XOR  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    function automatic int unsigned bundle_w(int unsigned xlen, int unsigned aw);
        return 4 + 2 * xlen + aw + 1;
    endfunction

    localparam int unsigned ALU_BUNDLE_W = 4 + 2 * ALU_XLEN + ALU_RF_AW + 1;

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry valid/ready skid buffer with synchronous flush.
//  - Main entry drives the output; the skid entry catches one input while main is stalled.
//  - in_ready_o is registered (low only while the skid entry is occupied).
// Ports:
//  clk_i, rst_ni             clock, async active-low reset
//  flush_i                   drop both entries and any input this cycle
//  in_valid_i/in_ready_o     upstream handshake, in_data_i payload
//  out_valid_o/out_ready_i   downstream handshake, out_data_o payload
module alu_skid_buf #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
);

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [Width-1:0] main_q, main_d;
    logic [Width-1:0] skid_q, skid_d;
    logic             in_acc;
    logic             out_xfer;

    assign in_ready_o  = ~skid_valid_q;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_q;

    assign in_acc   = in_valid_i & ~skid_valid_q;
    assign out_xfer = main_valid_q & out_ready_i;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_xfer) begin
            // Main is free at this edge: skid (older) wins; skid full implies no accept.
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = in_acc;
                if (in_acc) begin
                    main_d = in_data_i;
                end
            end
        end else if (in_acc) begin
            skid_d       = in_data_i;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Issue stage in front of the ALU.
//  - Decodes RV32I OP / OP-IMM / LUI into an ALU op and two operands.
//  - Forwards EX then WB results over register-file data; x0 always reads as zero.
//  - Registers the bundle through a 2-entry skid buffer (1-cycle latency, full throughput).
// Ports:
//  clk_i, rst_ni, flush_i                 clock, async active-low reset, sync flush
//  in_valid_i/in_ready_o, instr_i         upstream handshake and instruction word
//  rs1_data_i, rs2_data_i                 register-file reads for instr_i rs1/rs2
//  ex_fwd_*_i, wb_fwd_*_i                 forwarding sources (enable, rd, data)
//  out_valid_o/out_ready_i                ALU-side handshake
//  alu_op_o, src1_o, src2_o, rd_o         operand bundle
//  illegal_o                              instruction not handled by this stage
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RF_AW = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    input  logic             ex_fwd_en_i,
    input  logic [RF_AW-1:0] ex_fwd_rd_i,
    input  logic [XLEN-1:0]  ex_fwd_data_i,
    input  logic             wb_fwd_en_i,
    input  logic [RF_AW-1:0] wb_fwd_rd_i,
    input  logic [XLEN-1:0]  wb_fwd_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [3:0]       alu_op_o,
    output logic [XLEN-1:0]  src1_o,
    output logic [XLEN-1:0]  src2_o,
    output logic [RF_AW-1:0] rd_o,
    output logic             illegal_o
);

    localparam int unsigned BundleW = bundle_w(XLEN, RF_AW);

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [RF_AW-1:0] rs1_addr, rs2_addr, rd_addr;
    logic [XLEN-1:0]  fwd1, fwd2;
    logic [XLEN-1:0]  imm_i, shamt, imm_u;
    logic [31:0]      lui_word;
    logic             is_imm;

    logic [3:0]       dec_op;
    logic [XLEN-1:0]  dec_src1, dec_src2;
    logic [RF_AW-1:0] dec_rd;
    logic             dec_legal;

    logic [BundleW-1:0] in_bundle, out_bundle;

    assign opcode   = instr_i[6:0];
    assign rd_addr  = instr_i[11:7];
    assign funct3   = instr_i[14:12];
    assign rs1_addr = instr_i[19:15];
    assign rs2_addr = instr_i[24:20];
    assign funct7   = instr_i[31:25];
    assign is_imm   = (opcode == OPC_OPIMM);

    assign imm_i    = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
    assign shamt    = {{(XLEN-5){1'b0}}, instr_i[24:20]};
    assign lui_word = {instr_i[31:12], 12'b0};
    assign imm_u    = XLEN'(lui_word);

    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [RF_AW-1:0] rs,
        input logic [XLEN-1:0]  rf_data
    );
        if (rs == '0) begin
            return '0;
        end else if (ex_fwd_en_i && ex_fwd_rd_i == rs) begin
            return ex_fwd_data_i;
        end else if (wb_fwd_en_i && wb_fwd_rd_i == rs) begin
            return wb_fwd_data_i;
        end
        return rf_data;
    endfunction

    assign fwd1 = fwd_sel(rs1_addr, rs1_data_i);
    assign fwd2 = fwd_sel(rs2_addr, rs2_data_i);

    always_comb begin
        dec_op    = ALU_ADD;
        dec_src1  = fwd1;
        dec_src2  = is_imm ? imm_i : fwd2;
        dec_rd    = rd_addr;
        dec_legal = 1'b1;
        case (opcode)
            OPC_LUI: begin
                dec_src1 = '0;
                dec_src2 = imm_u;
            end
            OPC_OP, OPC_OPIMM: begin
                case (funct3)
                    3'b000: begin
                        // OP-IMM has no SUB; bits [31:25] are immediate there.
                        if (is_imm || funct7 == F7_BASE) begin
                            dec_op = ALU_ADD;
                        end else if (funct7 == F7_ALT) begin
                            dec_op = ALU_SUB;
                        end else begin
                            dec_legal = 1'b0;
                        end
                    end
                    3'b001: begin
                        dec_op = ALU_SLL;
                        if (funct7 != F7_BASE) dec_legal = 1'b0;
                        if (is_imm) dec_src2 = shamt;
                    end
                    3'b010: dec_op = ALU_SLT;
                    3'b011: dec_op = ALU_SLTU;
                    3'b100: dec_op = ALU_XOR;
                    3'b101: begin
                        if (funct7 == F7_BASE) begin
                            dec_op = ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            dec_op = ALU_SRA;
                        end else begin
                            dec_legal = 1'b0;
                        end
                        if (is_imm) dec_src2 = shamt;
                    end
                    3'b110: dec_op = ALU_OR;
                    3'b111: dec_op = ALU_AND;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
        if (!dec_legal) begin
            dec_op   = ALU_ADD;
            dec_src1 = '0;
            dec_src2 = '0;
            dec_rd   = '0;
        end
    end

    assign in_bundle = {dec_op, dec_src1, dec_src2, dec_rd, ~dec_legal};

    alu_skid_buf #(
        .Width (BundleW)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_bundle),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_bundle)
    );

    assign {alu_op_o, src1_o, src2_o, rd_o, illegal_o} = out_bundle;

endmodule
